// File: rtl/qedmma_track_scheduler.sv
// qedmma_track_scheduler
//   Time-shares a single IMM filter core between up to MAX_TARGETS tracks.
//   Tagged measurements arrive on an AXI-Stream slave (never back-pressured).
//   The latest measurement for each target is kept in a per-target buffer.
//   Pending targets are dispatched to the core in round-robin order with a
//   start/done handshake, and a watchdog recovers from a core that never
//   signals done.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   s_axis_meas_*       measurement stream: tdata = {z_y, z_x}, tuser = target id
//   active_mask         per-target enable; an inactive target drops input and
//                       has its pending flag held low
//   core_start          one-cycle dispatch pulse
//   core_tid/z_x/z_y    dispatched target and measurement, held until the
//                       next dispatch
//   core_done           core finished the current target (pulse)
//   pending             per-target measurement-waiting flags
//   busy                scheduler is not idle
//   timeout_pulse       one-cycle pulse on watchdog expiry
//   drop_cnt            saturating count of measurements for inactive targets
//   overwrite_cnt       saturating count of measurements replaced before dispatch
//   timeout_cnt         saturating count of watchdog expiries
module qedmma_track_scheduler #(
  parameter int MAX_TARGETS = 8,
  parameter int ID_W        = 3,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2*DATA_W-1:0]    s_axis_meas_tdata,
  input  logic [ID_W-1:0]        s_axis_meas_tuser,
  input  logic                   s_axis_meas_tvalid,
  output logic                   s_axis_meas_tready,
  input  logic [MAX_TARGETS-1:0] active_mask,
  output logic                   core_start,
  output logic [ID_W-1:0]        core_tid,
  output logic [DATA_W-1:0]      core_z_x,
  output logic [DATA_W-1:0]      core_z_y,
  input  logic                   core_done,
  output logic [MAX_TARGETS-1:0] pending,
  output logic                   busy,
  output logic                   timeout_pulse,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [CNT_W-1:0]       overwrite_cnt,
  output logic [CNT_W-1:0]       timeout_cnt
);

  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_WAIT
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0]      meas_x [MAX_TARGETS];
  logic [DATA_W-1:0]      meas_y [MAX_TARGETS];
  logic                   ready_q;
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        grant_q;
  logic [WD_W-1:0]        wd;
  logic [ID_W-1:0]        hold_tid;
  logic [DATA_W-1:0]      hold_x;
  logic [DATA_W-1:0]      hold_y;

  logic                   accept;
  logic                   in_active;
  logic                   ingest;
  logic [MAX_TARGETS-1:0] eligible;
  logic                   any_eligible;
  logic [ID_W-1:0]        grant_idx;
  logic [ID_W-1:0]        cand;
  logic                   found;
  logic [MAX_TARGETS-1:0] pend_set;
  logic [MAX_TARGETS-1:0] pend_clr;
  logic [MAX_TARGETS-1:0] pending_next;
  logic                   same_tgt_dispatch;
  logic                   drop_inc;
  logic                   overwrite_inc;
  logic                   timeout_hit;

  assign accept       = s_axis_meas_tvalid & ready_q;
  assign in_active    = active_mask[s_axis_meas_tuser];
  assign ingest       = accept & in_active;
  assign eligible     = pending & active_mask;
  assign any_eligible = |eligible;

  // Round-robin search starting just after rr_ptr. The last candidate
  // (k = MAX_TARGETS) wraps back to rr_ptr itself.
  always_comb begin
    grant_idx = rr_ptr;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= MAX_TARGETS; k++) begin
      cand = rr_ptr + ID_W'(k);
      if (!found && eligible[cand]) begin
        grant_idx = cand;
        found     = 1'b1;
      end
    end
  end

  // A new measurement for the target being dispatched this very cycle is
  // stored and keeps pending high (set wins over clear), but is not an overwrite:
  // the core receives the older value, and the new one is dispatched later.
  always_comb begin
    same_tgt_dispatch = (state == S_DISPATCH) && (grant_q == s_axis_meas_tuser);
    pend_set          = ingest ? (MAX_TARGETS'(1) << s_axis_meas_tuser) : '0;
    pend_clr          = (state == S_DISPATCH) ? (MAX_TARGETS'(1) << grant_q) : '0;
    pending_next      = ((pending & ~pend_clr) | pend_set) & active_mask;
    drop_inc          = accept & ~in_active;
    overwrite_inc     = ingest & pending[s_axis_meas_tuser] & ~same_tgt_dispatch;
  end

  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_eligible) state_next = S_DISPATCH;
      end
      S_DISPATCH: begin
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          state_next = S_IDLE;
        end else if (wd == WD_LAST) begin
          timeout_hit = 1'b1;
          state_next  = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q       <= 1'b0;
      rr_ptr        <= '1;
      grant_q       <= '0;
      wd            <= '0;
      hold_tid      <= '0;
      hold_x        <= '0;
      hold_y        <= '0;
      pending       <= '0;
      drop_cnt      <= '0;
      overwrite_cnt <= '0;
      timeout_cnt   <= '0;
      for (int unsigned i = 0; i < MAX_TARGETS; i++) begin
        meas_x[i] <= '0;
        meas_y[i] <= '0;
      end
    end else begin
      ready_q <= 1'b1;

      if (state == S_IDLE && any_eligible) begin
        grant_q <= grant_idx;
        rr_ptr  <= grant_idx;
      end

      // Outputs are driven straight from the buffer during DISPATCH and
      // captured here so a later write to the same slot cannot disturb them.
      if (state == S_DISPATCH) begin
        wd       <= '0;
        hold_tid <= grant_q;
        hold_x   <= meas_x[grant_q];
        hold_y   <= meas_y[grant_q];
      end else if (state == S_WAIT && !core_done && !timeout_hit) begin
        wd <= wd + 1'b1;
      end

      if (ingest) begin
        meas_x[s_axis_meas_tuser] <= s_axis_meas_tdata[DATA_W-1:0];
        meas_y[s_axis_meas_tuser] <= s_axis_meas_tdata[2*DATA_W-1:DATA_W];
      end

      pending <= pending_next;

      if (drop_inc && drop_cnt != '1)           drop_cnt      <= drop_cnt + 1'b1;
      if (overwrite_inc && overwrite_cnt != '1) overwrite_cnt <= overwrite_cnt + 1'b1;
      if (timeout_hit && timeout_cnt != '1)     timeout_cnt   <= timeout_cnt + 1'b1;
    end
  end

  assign s_axis_meas_tready = ready_q;
  assign core_start         = (state == S_DISPATCH);
  assign core_tid           = (state == S_DISPATCH) ? grant_q         : hold_tid;
  assign core_z_x           = (state == S_DISPATCH) ? meas_x[grant_q] : hold_x;
  assign core_z_y           = (state == S_DISPATCH) ? meas_y[grant_q] : hold_y;
  assign busy               = (state != S_IDLE);
  assign timeout_pulse      = timeout_hit;

endmodule

// File: tb/tb_qedmma_track_scheduler.sv
module tb_qedmma_track_scheduler;

  localparam int MT  = 8;
  localparam int IW  = 3;
  localparam int DW  = 32;
  localparam int TO  = 16;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2*DW-1:0] tdata;
  logic [IW-1:0] tuser;
  logic          tvalid;
  logic          tready;
  logic [MT-1:0] active_mask;
  logic          core_start;
  logic [IW-1:0] core_tid;
  logic [DW-1:0] core_z_x;
  logic [DW-1:0] core_z_y;
  logic          core_done;
  logic [MT-1:0] pending;
  logic          busy;
  logic          timeout_pulse;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] overwrite_cnt;
  logic [CW-1:0] timeout_cnt;

  int total = 0;
  int bad   = 0;

  qedmma_track_scheduler #(
    .MAX_TARGETS(MT),
    .ID_W(IW),
    .DATA_W(DW),
    .TIMEOUT_CYC(TO),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_axis_meas_tdata(tdata),
    .s_axis_meas_tuser(tuser),
    .s_axis_meas_tvalid(tvalid),
    .s_axis_meas_tready(tready),
    .active_mask(active_mask),
    .core_start(core_start),
    .core_tid(core_tid),
    .core_z_x(core_z_x),
    .core_z_y(core_z_y),
    .core_done(core_done),
    .pending(pending),
    .busy(busy),
    .timeout_pulse(timeout_pulse),
    .drop_cnt(drop_cnt),
    .overwrite_cnt(overwrite_cnt),
    .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  typedef struct {
    logic [IW-1:0] tid;
    logic [MT-1:0] mask;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [MT-1:0] exp_pend;
    logic          exp_start;
    logic [IW-1:0] exp_tid;
    logic [DW-1:0] exp_x;
    logic [DW-1:0] exp_y;
    logic [CW-1:0] exp_drop;
  } vec_t;

  vec_t vecs [6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [IW-1:0] id, input logic [DW-1:0] x, input logic [DW-1:0] y);
    tvalid = 1'b1;
    tuser  = id;
    tdata  = {y, x};
    tick();
    tvalid = 1'b0;
  endtask

  task automatic pulse_done;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
  endtask

  initial begin
    int n;
    rst_n       = 1'b0;
    tvalid      = 1'b0;
    tuser       = '0;
    tdata       = '0;
    active_mask = '1;
    core_done   = 1'b0;

    vecs[0] = '{3'd5, 8'hFF, 32'h0001_0000, 32'hFFFF_0000, 8'h20, 1'b1, 3'd5, 32'h0001_0000, 32'hFFFF_0000, 16'd0};
    vecs[1] = '{3'd4, 8'hEF, 32'h1234_5678, 32'h9ABC_DEF0, 8'h00, 1'b0, 3'd5, 32'h0001_0000, 32'hFFFF_0000, 16'd1};
    vecs[2] = '{3'd0, 8'hFF, 32'h7FFF_FFFF, 32'h8000_0000, 8'h01, 1'b1, 3'd0, 32'h7FFF_FFFF, 32'h8000_0000, 16'd1};
    vecs[3] = '{3'd7, 8'h80, 32'h0000_0001, 32'h0000_0002, 8'h80, 1'b1, 3'd7, 32'h0000_0001, 32'h0000_0002, 16'd1};
    vecs[4] = '{3'd7, 8'h7F, 32'h5555_AAAA, 32'hAAAA_5555, 8'h00, 1'b0, 3'd7, 32'h0000_0001, 32'h0000_0002, 16'd2};
    vecs[5] = '{3'd3, 8'hFF, 32'hDEAD_BEEF, 32'hCAFE_F00D, 8'h08, 1'b1, 3'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 16'd2};

    // reset state
    repeat (3) tick();
    chk("rst_tready", 64'(tready), 64'd0);
    chk("rst_start", 64'(core_start), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_zx", 64'(core_z_x), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_tready_before_edge", 64'(tready), 64'd0);
    tick();
    chk("rel_tready_after_edge", 64'(tready), 64'd1);

    // single-measurement vectors
    for (int i = 0; i < 6; i++) begin
      active_mask = vecs[i].mask;
      send(vecs[i].tid, vecs[i].x, vecs[i].y);
      chk($sformatf("v%0d_pending", i), 64'(pending), 64'(vecs[i].exp_pend));
      chk($sformatf("v%0d_nostart_yet", i), 64'(core_start), 64'd0);
      tick();
      chk($sformatf("v%0d_start", i), 64'(core_start), 64'(vecs[i].exp_start));
      chk($sformatf("v%0d_tid", i), 64'(core_tid), 64'(vecs[i].exp_tid));
      chk($sformatf("v%0d_zx", i), 64'(core_z_x), 64'(vecs[i].exp_x));
      chk($sformatf("v%0d_zy", i), 64'(core_z_y), 64'(vecs[i].exp_y));
      chk($sformatf("v%0d_drop", i), 64'(drop_cnt), 64'(vecs[i].exp_drop));
      if (vecs[i].exp_start) begin
        tick();
        chk($sformatf("v%0d_pend_cleared", i), 64'(pending), 64'd0);
        pulse_done();
      end
      chk($sformatf("v%0d_idle", i), 64'(busy), 64'd0);
      active_mask = '1;
    end

    // round robin: dispatch 3 first so rr_ptr=3, then 1,3,6 become pending
    send(3'd3, 32'h0000_0033, 32'h0000_0330);
    tick();
    chk("rr_first_tid", 64'(core_tid), 64'd3);
    tick();
    send(3'd1, 32'h0000_0011, 32'h0000_0110);
    send(3'd3, 32'h0000_0034, 32'h0000_0340);
    send(3'd6, 32'h0000_0066, 32'h0000_0660);
    chk("rr_pending", 64'(pending), 64'h4A);
    chk("rr_busy_wait", 64'(busy), 64'd1);
    pulse_done();
    tick();
    chk("rr_d1_start", 64'(core_start), 64'd1);
    chk("rr_d1_tid", 64'(core_tid), 64'd6);
    tick();
    pulse_done();
    tick();
    chk("rr_d2_start", 64'(core_start), 64'd1);
    chk("rr_d2_tid", 64'(core_tid), 64'd1);
    tick();
    pulse_done();
    tick();
    chk("rr_d3_start", 64'(core_start), 64'd1);
    chk("rr_d3_tid", 64'(core_tid), 64'd3);
    chk("rr_d3_zx", 64'(core_z_x), 64'h34);
    tick();
    pulse_done();
    chk("rr_busy_end", 64'(busy), 64'd0);
    chk("rr_ovw_none", 64'(overwrite_cnt), 64'd0);

    // overwrite before dispatch: second value wins
    send(3'd2, 32'h0000_00A0, 32'h0000_0A00);
    send(3'd2, 32'h0000_00B0, 32'h0000_0B00);
    chk("ovw_start", 64'(core_start), 64'd1);
    chk("ovw_tid", 64'(core_tid), 64'd2);
    chk("ovw_zx", 64'(core_z_x), 64'hB0);
    chk("ovw_zy", 64'(core_z_y), 64'hB00);
    chk("ovw_cnt", 64'(overwrite_cnt), 64'd1);
    tick();
    pulse_done();
    chk("ovw_pending", 64'(pending), 64'd0);

    // same-cycle ingest and dispatch of target 0
    send(3'd0, 32'h0000_D000, 32'h000D_0000);
    tick();
    chk("same_start", 64'(core_start), 64'd1);
    chk("same_zx_d", 64'(core_z_x), 64'hD000);
    send(3'd0, 32'h0000_C000, 32'h000C_0000);
    chk("same_hold_zx", 64'(core_z_x), 64'hD000);
    chk("same_hold_zy", 64'(core_z_y), 64'hD_0000);
    chk("same_pending", 64'(pending), 64'h01);
    chk("same_ovw", 64'(overwrite_cnt), 64'd1);
    pulse_done();
    tick();
    chk("same_d2_start", 64'(core_start), 64'd1);
    chk("same_d2_zx", 64'(core_z_x), 64'hC000);
    tick();
    pulse_done();

    // watchdog: core never answers for target 1; target 2 waits behind it
    send(3'd1, 32'h0000_0E00, 32'h0000_E000);
    tick();
    chk("to_start", 64'(core_start), 64'd1);
    send(3'd2, 32'h0000_0F00, 32'h0000_F000);
    n = 1;
    while (!timeout_pulse && n < 40) begin
      tick();
      n++;
    end
    chk("to_latency", 64'(n), 64'd16);
    chk("to_busy_at_pulse", 64'(busy), 64'd1);
    tick();
    chk("to_pulse_once", 64'(timeout_pulse), 64'd0);
    chk("to_cnt", 64'(timeout_cnt), 64'd1);
    chk("to_idle", 64'(busy), 64'd0);
    tick();
    chk("to_next_start", 64'(core_start), 64'd1);
    chk("to_next_tid", 64'(core_tid), 64'd2);
    tick();
    pulse_done();

    // reset while waiting on the core
    send(3'd6, 32'h0000_6000, 32'h0006_0000);
    tick();
    tick();
    send(3'd5, 32'h0000_5000, 32'h0005_0000);
    chk("mid_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_tready", 64'(tready), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_tid", 64'(core_tid), 64'd0);
    chk("mid_zx", 64'(core_z_x), 64'd0);
    chk("mid_pending", 64'(pending), 64'd0);
    chk("mid_drop", 64'(drop_cnt), 64'd0);
    chk("mid_ovw", 64'(overwrite_cnt), 64'd0);
    chk("mid_tocnt", 64'(timeout_cnt), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_tready_back", 64'(tready), 64'd1);
    pulse_done();
    chk("mid_done_ignored_busy", 64'(busy), 64'd0);
    tick();
    chk("mid_done_ignored_start", 64'(core_start), 64'd0);
    chk("mid_done_ignored_pend", 64'(pending), 64'd0);
    chk("mid_done_ignored_tocnt", 64'(timeout_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
